// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: FSM state encodings, the
// read/write flag position in the command byte and the special read addresses.
package spi_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GET_DATA  = 2'd1,
        READ_WAIT = 2'd2
    } cmd_state_t;

    localparam int         RW_BIT      = 7;
    localparam logic [6:0] ADDR_STATUS = 7'h7E;
    localparam logic [6:0] ADDR_ID     = 7'h7F;

endpackage

// File: rtl/spi_cmd_decoder_sync_2ff.sv
// 1-bit two-flop synchroniser with a configurable value loaded during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI-received bytes into register writes/reads and drives the readback byte.
// Optional macro CMD_TIMEOUT_EN aborts a partial command after TIMEOUT_CYCLES clocks.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int         NUM_REGS       = 8,
    parameter logic [7:0] ID_VALUE       = 8'hC4,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  spi_cs_n,
    output logic [7:0]            tx_byte,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic [7:0]            err_count
);

    logic valid_s, valid_d, cs_s, cs_d;
    logic capture, cs_rise, timeout;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_valid (.clk(clk), .rst_n(rst_n), .d(rx_valid), .q(valid_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs    (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            valid_d <= valid_s;
            cs_d    <= cs_s;
        end
    end

    assign capture = valid_s & ~valid_d;
    assign cs_rise = cs_s & ~cs_d;

    cmd_state_t              state, next_state;
    logic [6:0]              addr;
    logic                    load_pend;
    logic [NUM_REGS-1:0][7:0] regs;
    logic [7:0]              rd_data;
    logic                    do_write, start_read, err_inc;

    assign regs_flat = regs;

`ifdef CMD_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          tmo_cnt <= '0;
        else if (capture || state == IDLE)   tmo_cnt <= '0;
        else                                 tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Fires on the TIMEOUT_CYCLES-th clock spent waiting in a partial command
    assign timeout = (state != IDLE) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        start_read = 1'b0;
        err_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    if (rx_byte[RW_BIT]) begin
                        start_read = 1'b1;
                        next_state = READ_WAIT;
                        if (int'(rx_byte[6:0]) >= NUM_REGS && rx_byte[6:0] != ADDR_STATUS
                            && rx_byte[6:0] != ADDR_ID)
                            err_inc = 1'b1;
                    end else begin
                        next_state = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (capture) begin
                    if (int'(addr) < NUM_REGS) do_write = 1'b1;
                    else                       err_inc  = 1'b1;
                    next_state = IDLE;
                end else if (cs_rise || timeout) begin
                    err_inc    = 1'b1;
                    next_state = IDLE;
                end
            end
            READ_WAIT: begin
                if (capture || cs_rise) begin
                    next_state = IDLE;
                end else if (timeout) begin
                    err_inc    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // A chip-select rise always ends the command, after any same-cycle capture
        if (cs_rise) next_state = IDLE;
    end

    always_comb begin
        rd_data = 8'h00;
        if (addr == ADDR_STATUS)  rd_data = status_in;
        else if (addr == ADDR_ID) rd_data = ID_VALUE;
        for (int k = 0; k < NUM_REGS; k++)
            if (addr == 7'(k)) rd_data = regs[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            load_pend <= 1'b0;
            tx_byte   <= 8'h00;
            regs      <= '0;
            wr_strobe <= '0;
            err_count <= 8'h00;
        end else begin
            if (state == IDLE && capture) addr <= rx_byte[6:0];
            load_pend <= start_read && (next_state == READ_WAIT);
            if (next_state != READ_WAIT) tx_byte <= 8'h00;
            else if (load_pend)          tx_byte <= rd_data;
            for (int k = 0; k < NUM_REGS; k++) begin
                wr_strobe[k] <= do_write && (addr == 7'(k));
                if (do_write && addr == 7'(k)) regs[k] <= rx_byte;
            end
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: host-side byte/frame tasks plus hand-computed expectations.
module tb_spi_cmd_decoder;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          spi_cs_n;
    logic [7:0]    tx_byte;
    logic [7:0]    status_in;
    logic [NR*8-1:0] regs_flat;
    logic [NR-1:0] wr_strobe;
    logic [7:0]    err_count;

    logic [NR-1:0][7:0] exp_regs;
    int n_tests = 0;
    int n_fail  = 0;
    int str_hits[NR];
    logic str_clr = 1'b1;

    spi_cmd_decoder #(.NUM_REGS(NR), .ID_VALUE(8'hC4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .spi_cs_n(spi_cs_n), .tx_byte(tx_byte), .status_in(status_in),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) begin
            if (str_clr)           str_hits[k] = 0;
            else if (wr_strobe[k]) str_hits[k] = str_hits[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_str();
        str_clr = 1'b1;
        @(posedge clk); @(posedge clk);
        str_clr = 1'b0;
    endtask

    function automatic int other_hits(input int skip);
        int s = 0;
        for (int k = 0; k < NR; k++) if (k != skip) s += str_hits[k];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        repeat (6) @(posedge clk);
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        exp_regs = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; spi_cs_n = 1'b1; status_in = 8'h00;
        exp_regs = '0;
        #12;
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_regs", regs_flat, 64'h0);
        chk("rst_strobe", wr_strobe, 8'h00);
        chk("rst_err", err_count, 8'h00);
        do_reset();

        // Write reg 3
        clr_str();
        cs_low(); send_byte(8'h03); send_byte(8'h5A); cs_high();
        exp_regs[3] = 8'h5A;
        chk("wr3_regs", regs_flat, exp_regs);
        chk("wr3_strobe_cnt", str_hits[3], 1);
        chk("wr3_other_strobes", other_hits(3), 0);
        chk("wr3_err", err_count, 8'h00);
        chk("wr3_tx_idle", tx_byte, 8'h00);

        // Highest valid address
        clr_str();
        cs_low(); send_byte(8'h07); send_byte(8'hA5); cs_high();
        exp_regs[7] = 8'hA5;
        chk("wr7_regs", regs_flat, exp_regs);
        chk("wr7_strobe_cnt", str_hits[7], 1);

        // Read back reg 3
        cs_low(); send_byte(8'h83);
        chk("rd3_tx", tx_byte, 8'h5A);
        send_byte(8'h00);
        chk("rd3_tx_after_dummy", tx_byte, 8'h00);
        cs_high();

        // ID and status reads
        cs_low(); send_byte(8'hFF);
        chk("rd_id", tx_byte, 8'hC4);
        send_byte(8'h00); cs_high();
        status_in = 8'h81;
        cs_low(); send_byte(8'hFE);
        chk("rd_status", tx_byte, 8'h81);
        send_byte(8'h00); cs_high();
        chk("rd_err", err_count, 8'h00);

        // Out-of-range write and read
        clr_str();
        cs_low(); send_byte(8'h10); send_byte(8'h77); cs_high();
        chk("bad_wr_strobes", other_hits(-1), 0);
        chk("bad_wr_regs", regs_flat, exp_regs);
        chk("bad_wr_err", err_count, 8'h01);
        cs_low(); send_byte(8'h90);
        chk("bad_rd_tx", tx_byte, 8'h00);
        chk("bad_rd_err", err_count, 8'h02);
        send_byte(8'h00); cs_high();

        // Read aborted by cs_n is not an error
        cs_low(); send_byte(8'h83); cs_high();
        chk("rd_abort_tx", tx_byte, 8'h00);
        chk("rd_abort_err", err_count, 8'h02);

        // Write aborted by cs_n
        do_reset();
        cs_low(); send_byte(8'h02); cs_high();
        chk("abort_regs", regs_flat, exp_regs);
        chk("abort_err", err_count, 8'h01);
        cs_low(); send_byte(8'h02); send_byte(8'h11); cs_high();
        exp_regs[2] = 8'h11;
        chk("after_abort_regs", regs_flat, exp_regs);
        chk("after_abort_err", err_count, 8'h01);

        // Reset in the middle of a write
        cs_low(); send_byte(8'h05);
        rst_n = 1'b0;
        #1;
        chk("midrst_regs", regs_flat, 64'h0);
        chk("midrst_tx", tx_byte, 8'h00);
        chk("midrst_err", err_count, 8'h00);
        chk("midrst_strobe", wr_strobe, 8'h00);
        spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        exp_regs = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);

`ifdef CMD_TIMEOUT_EN
        cs_low(); send_byte(8'h01);
        repeat (110) @(posedge clk);
        @(negedge clk);
        chk("tmo_err", err_count, 8'h01);
        send_byte(8'hFF);
        chk("tmo_idle_rd_id", tx_byte, 8'hC4);
        send_byte(8'h00); cs_high();
        chk("tmo_regs", regs_flat, exp_regs);
`else
        cs_low(); send_byte(8'h01);
        repeat (200) @(posedge clk);
        send_byte(8'h44); cs_high();
        exp_regs[1] = 8'h44;
        chk("wait_regs", regs_flat, exp_regs);
        chk("wait_err", err_count, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
